mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file read ports: operands a/b come from regfile qa/qb, and op comes from the decoder.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. hi/lo feed the MFHI/MFLO writeback mux, and busy stalls the pipeline.
- Shared radix-2 datapath, 33 cycles per multiply/divide.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk    in   1     clock; all state updates on its rising edge.
- clrn   in   1     synchronous, active-high reset; sampled on the rising edge of clk.
- start  in   1     request strobe; op/a/b are valid while high.
- op     in   3     operation code (see mdu_pkg).
- a      in   XLEN  rs operand (regfile qa).
- b      in   XLEN  rt operand (regfile qb).
- hi     out  XLEN  HI register.
- lo     out  XLEN  LO register.
- busy   out  1     multiply/divide in progress.
- done   out  1     one-cycle pulse when hi/lo take a mul/div result.

Behaviour:
- Reset (clrn=1 at an edge):
  - hi=0, lo=0, busy=0, done=0, counter=0, FSM=IDLE.
  - Takes priority over every other event.
  - Mid-operation reset aborts the operation; no result is written.
- Op encoding:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111: no-op; start is accepted but nothing changes.
- Acceptance: start is sampled only when FSM=IDLE. start while busy is ignored and not queued; the upstream stall guarantees a retry.
- MTHI/MTLO:
  - Single cycle: hi<=a (or lo<=a) at the accepting edge.
  - busy and done stay 0.
- FSM states: IDLE -> RUN -> FIX -> IDLE.
  - IDLE, start with a mul/div op at edge T0:
    - Latch |a| and |b| (signed ops) or a and b raw (unsigned ops).
    - Latch the sign flags and the op.
    - counter<=XLEN, go to RUN.
  - RUN: one radix-2 step per edge, counter decrements. When counter reaches 0, go to FIX.
    - Multiply step: shift-add on a {acc, multiplier} 2*XLEN register.
    - Divide step: restoring shift-subtract on {rem, quot}.
  - FIX: apply sign correction, write hi/lo, done<=1 for exactly one cycle, go to IDLE.
- Timing:
  - busy=1 during cycles T0+1 .. T0+33 (RUN plus FIX).
  - hi/lo updated and done=1 in cycle T0+34, with busy=0 in that cycle.
  - A new start is accepted in the same cycle that done=1.
- Multiply:
  - {hi,lo} = full 2*XLEN product.
  - Signed product is negated when sign(a)^sign(b).
- Divide:
  - lo = quotient, truncated toward zero; hi = remainder.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
- Divide by zero (b=0):
  - Full latency is kept.
  - lo=all ones, hi=a (unmodified dividend), for both DIV and DIVU.
- Outside reset and the FIX/MTxx edges, hi/lo hold their values.
- hi/lo keep their old values while busy (no intermediate values are visible).
- All arithmetic is unsigned on magnitudes. Negation is two's complement at XLEN or 2*XLEN width.

Decomposition:
- mdu_pkg:
  - op codes MDU_MULT..MDU_MTLO.
  - FSM state enum (IDLE, RUN, FIX).
  - XLEN default.
- Sub-module mdu_iter_core: combinational one-step datapath. Given op class and current {upper, lower, operand}, it returns the next {upper, lower}.
- mdu_hilo owns the FSM, counter, sign fix, and HI/LO.

Test Plan:
- Reset then MULT a=0xFFFFFFFD (-3), b=5 -> busy high 33 cycles; at T0+34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> after 34 cycles lo=0xFFFFFFFF, hi=0x1234, done pulse of width 1.
- MULT in flight, then start MTHI a=0xAAAA at T0+10 -> ignored; hi=product at done. MTLO a=0x55 issued in the done cycle -> lo=0x55 next edge, busy stays 0.
- DIV started, clrn=1 at T0+15 -> next cycle hi=lo=0, busy=0, done never pulses; a fresh MULTU 3*4 then completes with lo=12, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step of the shared datapath: shift-add multiply or restoring shift-subtract divide.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] upper,
  input  logic [XLEN-1:0] lower,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] upper_n,
  output logic [XLEN-1:0] lower_n
);

  logic [XLEN:0]   madd;
  logic [XLEN:0]   shl;
  logic [XLEN-1:0] diff;
  logic            fits;

  assign madd = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : '0);
  assign shl  = {upper, lower[XLEN-1]};
  assign fits = (shl >= {1'b0, opnd});
  // When the subtraction fits the true difference is below opnd, so XLEN bits suffice.
  assign diff = shl[XLEN-1:0] - opnd;

  always_comb begin
    upper_n = upper;
    lower_n = lower;
    if (is_div) begin
      upper_n = fits ? diff : shl[XLEN-1:0];
      lower_n = {lower[XLEN-2:0], fits};
    end else begin
      {upper_n, lower_n} = {madd, lower[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Magnitudes are iterated unsigned for XLEN steps, then sign-corrected in FIX.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] upper_q, upper_d, lower_q, lower_d, opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            isdiv_q, isdiv_d, negp_q, negp_d, negr_q, negr_d, dz_q, dz_d;
  logic            done_q, done_d;

  logic            sgn_op, a_neg, b_neg;
  logic [XLEN-1:0] step_upper, step_lower;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg    = sgn_op & a[XLEN-1];
  assign b_neg    = sgn_op & b[XLEN-1];
  assign prod     = {upper_q, lower_q};
  assign prod_fix = negp_q ? -prod : prod;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .is_div  (isdiv_q),
    .upper   (upper_q),
    .lower   (lower_q),
    .opnd    (opnd_q),
    .upper_n (step_upper),
    .lower_n (step_lower)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upper_d = upper_q;
    lower_d = lower_q;
    opnd_d  = opnd_q;
    isdiv_d = isdiv_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              isdiv_d = op[1];
              lower_d = a_neg ? -a : a;
              opnd_d  = b_neg ? -b : b;
              upper_d = '0;
              negp_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              dz_d    = (b == '0);
              cnt_d   = CNT_W'(XLEN);
              state_d = ST_RUN;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        upper_d = step_upper;
        lower_d = step_lower;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (isdiv_q) begin
          // Divide by zero leaves quotient all ones and remainder = |a|; skipping the
          // quotient negation and applying the remainder sign yields lo=~0, hi=a.
          lo_d = (negp_q && !dz_q) ? -lower_q : lower_q;
          hi_d = negr_q ? -upper_q : upper_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      upper_q <= '0;
      lower_q <= '0;
      opnd_q  <= '0;
      isdiv_q <= 1'b0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      opnd_q  <= opnd_d;
      isdiv_q <= isdiv_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
